lcd_packet_fifo: RTL and testbench

Single-clock, parametrised Avalon-ST packet FIFO for the LCD video path. It carries data, empty, startofpacket and endofpacket beats between the pixel DMA and downstream pixel-format stages that share one clock domain. Width, depth and almost-full threshold are parameters. It adds two features not available before: a fill-level output and an optional store-and-forward mode, which holds output until a complete packet is buffered.

---
 rtl/lcd_packet_fifo.sv | 138 +++++++++++++
 tb/tb_lcd_packet_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lcd_packet_fifo
// Function : Single-clock Avalon-ST packet FIFO with fill level, packet count
//            and optional store-and-forward output gating.
// Revision : 1.0
// ============================================================================
module lcd_packet_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = 3,
  parameter int DEPTH         = 128,
  parameter int ALMOST_FULL   = 124,
  parameter int STORE_FORWARD = 0,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  avalonst_sink_data,
  input  logic [EMPTY_WIDTH-1:0] avalonst_sink_empty,
  input  logic                   avalonst_sink_startofpacket,
  input  logic                   avalonst_sink_endofpacket,
  input  logic                   avalonst_sink_valid,
  output logic                   avalonst_sink_ready,
  output logic [DATA_WIDTH-1:0]  avalonst_source_data,
  output logic [EMPTY_WIDTH-1:0] avalonst_source_empty,
  output logic                   avalonst_source_startofpacket,
  output logic                   avalonst_source_endofpacket,
  output logic                   avalonst_source_valid,
  input  logic                   avalonst_source_ready,
  output logic [AW:0]            fill_level,
  output logic [AW:0]            pkt_count,
  output logic                   almost_full
);

  localparam int          c_EW   = DATA_WIDTH + EMPTY_WIDTH + 2;
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_AF   = (AW+1)'(ALMOST_FULL);

  logic [c_EW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_fill;
  logic [AW:0]     r_pkt;
  logic            r_af;
  logic            r_rst_done;

  logic [AW:0]     w_fill_nxt;
  logic [AW:0]     w_pkt_nxt;
  logic [c_EW-1:0] w_head;
  logic [c_EW-1:0] w_wr_entry;
  logic            w_full;
  logic            w_nonempty;
  logic            w_sink_ready;
  logic            w_src_valid;
  logic            w_wr;
  logic            w_rd;
  logic            w_pkt_inc;
  logic            w_pkt_dec;

  assign w_full       = (r_fill == c_FULL);
  assign w_nonempty   = (r_fill != '0);
  assign w_sink_ready = r_rst_done & ~w_full;

  // A full FIFO with no EOP stored releases data so oversized packets cannot deadlock.
  generate
    if (STORE_FORWARD != 0) begin : g_store_forward
      assign w_src_valid = w_nonempty & ((r_pkt != '0) | w_full);
    end else begin : g_cut_through
      assign w_src_valid = w_nonempty;
    end
  endgenerate

  assign w_wr       = avalonst_sink_valid & w_sink_ready;
  assign w_rd       = w_src_valid & avalonst_source_ready;
  assign w_wr_entry = {avalonst_sink_startofpacket, avalonst_sink_endofpacket,
                       avalonst_sink_empty, avalonst_sink_data};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pkt_inc  = w_wr & avalonst_sink_endofpacket;
  assign w_pkt_dec  = w_rd & w_head[c_EW-2];

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_wr & ~w_rd) begin
      w_fill_nxt = r_fill + 1'b1;
    end else if (~w_wr & w_rd) begin
      w_fill_nxt = r_fill - 1'b1;
    end
  end

  always_comb begin
    w_pkt_nxt = r_pkt;
    if (w_pkt_inc & ~w_pkt_dec) begin
      w_pkt_nxt = r_pkt + 1'b1;
    end else if (~w_pkt_inc & w_pkt_dec) begin
      w_pkt_nxt = r_pkt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_pkt      <= '0;
      r_af       <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_fill     <= w_fill_nxt;
      r_pkt      <= w_pkt_nxt;
      r_af       <= (w_fill_nxt >= c_AF);
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign avalonst_sink_ready           = w_sink_ready;
  assign avalonst_source_valid         = w_src_valid;
  assign avalonst_source_startofpacket = w_head[c_EW-1];
  assign avalonst_source_endofpacket   = w_head[c_EW-2];
  assign avalonst_source_empty         = w_head[DATA_WIDTH +: EMPTY_WIDTH];
  assign avalonst_source_data          = w_head[DATA_WIDTH-1:0];
  assign fill_level                    = r_fill;
  assign pkt_count                     = r_pkt;
  assign almost_full                   = r_af;

endmodule
`default_nettype wire

// File: tb/tb_lcd_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_packet_fifo
// Function : Queue-model scoreboard bench for a cut-through and a
//            store-and-forward instance of lcd_packet_fifo.
// Revision : 1.0
// ============================================================================
module tb_lcd_packet_fifo;

  localparam int A_DEPTH = 128;
  localparam int A_AF    = 124;
  localparam int B_DEPTH = 16;
  localparam int B_AF    = 14;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t       a_in;
  logic        a_valid = 1'b0, a_src_ready = 1'b0;
  logic        a_ready, a_out_valid, a_sop, a_eop, a_af;
  logic [63:0] a_data;
  logic [2:0]  a_empty;
  logic [7:0]  a_fill, a_pkt;
  int          a_rmode = 0;

  beat_t       b_in;
  logic        b_valid = 1'b0, b_src_ready = 1'b0;
  logic        b_ready, b_out_valid, b_sop, b_eop, b_af;
  logic [63:0] b_data;
  logic [2:0]  b_empty;
  logic [4:0]  b_fill, b_pkt;
  int          b_rmode = 0;

  lcd_packet_fifo #(.DATA_WIDTH(64), .EMPTY_WIDTH(3), .DEPTH(A_DEPTH),
                    .ALMOST_FULL(A_AF), .STORE_FORWARD(0)) u_ct (
    .clk(clk), .reset_n(reset_n),
    .avalonst_sink_data(a_in.data), .avalonst_sink_empty(a_in.empty),
    .avalonst_sink_startofpacket(a_in.sop), .avalonst_sink_endofpacket(a_in.eop),
    .avalonst_sink_valid(a_valid), .avalonst_sink_ready(a_ready),
    .avalonst_source_data(a_data), .avalonst_source_empty(a_empty),
    .avalonst_source_startofpacket(a_sop), .avalonst_source_endofpacket(a_eop),
    .avalonst_source_valid(a_out_valid), .avalonst_source_ready(a_src_ready),
    .fill_level(a_fill), .pkt_count(a_pkt), .almost_full(a_af)
  );

  lcd_packet_fifo #(.DATA_WIDTH(64), .EMPTY_WIDTH(3), .DEPTH(B_DEPTH),
                    .ALMOST_FULL(B_AF), .STORE_FORWARD(1)) u_sf (
    .clk(clk), .reset_n(reset_n),
    .avalonst_sink_data(b_in.data), .avalonst_sink_empty(b_in.empty),
    .avalonst_sink_startofpacket(b_in.sop), .avalonst_sink_endofpacket(b_in.eop),
    .avalonst_sink_valid(b_valid), .avalonst_sink_ready(b_ready),
    .avalonst_source_data(b_data), .avalonst_source_empty(b_empty),
    .avalonst_source_startofpacket(b_sop), .avalonst_source_endofpacket(b_eop),
    .avalonst_source_valid(b_out_valid), .avalonst_source_ready(b_src_ready),
    .fill_level(b_fill), .pkt_count(b_pkt), .almost_full(b_af)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference models: a queue of stored beats per instance, checked mid-cycle.
  beat_t a_q[$];
  bit    a_rdone = 1'b0;
  beat_t b_q[$];
  bit    b_rdone = 1'b0;

  always @(negedge clk) begin
    int    np;
    bit    ev, er;
    beat_t hb;
    if (!reset_n) begin
      a_q.delete();
      a_rdone = 1'b0;
    end
    np = 0;
    foreach (a_q[i]) if (a_q[i].eop) np++;
    er = a_rdone && (a_q.size() < A_DEPTH);
    ev = (a_q.size() != 0);
    chk("a_sink_ready", 64'(a_ready), 64'(er));
    chk("a_source_valid", 64'(a_out_valid), 64'(ev));
    chk("a_fill_level", 64'(a_fill), 64'(a_q.size()));
    chk("a_pkt_count", 64'(a_pkt), 64'(np));
    chk("a_almost_full", 64'(a_af), 64'(a_q.size() >= A_AF));
    if (ev && a_src_ready) begin
      hb = a_q[0];
      chk("a_out_data", a_data, hb.data);
      chk("a_out_ctl", 64'({a_sop, a_eop, a_empty}), 64'({hb.sop, hb.eop, hb.empty}));
    end
    if (reset_n) begin
      if (ev && a_src_ready) void'(a_q.pop_front());
      if (er && a_valid) a_q.push_back(a_in);
      a_rdone = 1'b1;
    end
  end

  always @(negedge clk) begin
    int    np;
    bit    ev, er;
    beat_t hb;
    if (!reset_n) begin
      b_q.delete();
      b_rdone = 1'b0;
    end
    np = 0;
    foreach (b_q[i]) if (b_q[i].eop) np++;
    er = b_rdone && (b_q.size() < B_DEPTH);
    ev = (b_q.size() != 0) && ((np != 0) || (b_q.size() == B_DEPTH));
    chk("b_sink_ready", 64'(b_ready), 64'(er));
    chk("b_source_valid", 64'(b_out_valid), 64'(ev));
    chk("b_fill_level", 64'(b_fill), 64'(b_q.size()));
    chk("b_pkt_count", 64'(b_pkt), 64'(np));
    chk("b_almost_full", 64'(b_af), 64'(b_q.size() >= B_AF));
    if (ev && b_src_ready) begin
      hb = b_q[0];
      chk("b_out_data", b_data, hb.data);
      chk("b_out_ctl", 64'({b_sop, b_eop, b_empty}), 64'({hb.sop, hb.eop, hb.empty}));
    end
    if (reset_n) begin
      if (ev && b_src_ready) void'(b_q.pop_front());
      if (er && b_valid) b_q.push_back(b_in);
      b_rdone = 1'b1;
    end
  end

  function automatic beat_t mk(input int sop, input int eop, input int emp, input logic [63:0] d);
    beat_t bt;
    bt.sop   = 1'(sop);
    bt.eop   = 1'(eop);
    bt.empty = 3'(emp);
    bt.data  = d;
    return bt;
  endfunction

  task automatic a_cycles(input int n);
    repeat (n) begin
      if (a_rmode == 2) a_src_ready = 1'($urandom_range(0, 1));
      else a_src_ready = (a_rmode == 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic b_cycles(input int n);
    repeat (n) begin
      if (b_rmode == 2) b_src_ready = 1'($urandom_range(0, 1));
      else b_src_ready = (b_rmode == 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic a_push(input beat_t bt);
    bit acc;
    int guard;
    guard = 0;
    a_in = bt;
    a_valid = 1'b1;
    do begin
      if (a_rmode == 2) a_src_ready = 1'($urandom_range(0, 1));
      else a_src_ready = (a_rmode == 1);
      @(negedge clk); acc = a_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 400);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL a_push_timeout actual=stalled required=accepted time=%0t", $time);
    end
    a_valid = 1'b0;
  endtask

  task automatic b_push(input beat_t bt);
    bit acc;
    int guard;
    guard = 0;
    b_in = bt;
    b_valid = 1'b1;
    do begin
      if (b_rmode == 2) b_src_ready = 1'($urandom_range(0, 1));
      else b_src_ready = (b_rmode == 1);
      @(negedge clk); acc = b_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 400);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL b_push_timeout actual=stalled required=accepted time=%0t", $time);
    end
    b_valid = 1'b0;
  endtask

  initial begin
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_low_first_cycle_after_release", 64'(a_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_high_after_second_edge", 64'(a_ready), 64'd1);
    @(posedge clk); #1;

    // Cut-through streaming, incrementing data, random backpressure and gaps.
    a_rmode = 2;
    for (int i = 0; i < 300; i++) begin
      a_push(mk(int'(i % 10 == 0), int'(i % 10 == 9), i % 8, 64'(i)));
      if ($urandom_range(0, 3) == 0) a_cycles(1);
    end
    a_rmode = 1;
    a_cycles(140);
    @(negedge clk);
    chk("ct_drained_fill", 64'(a_fill), 64'd0);
    @(posedge clk); #1;

    // Full boundary.
    a_rmode = 0;
    for (int i = 0; i < A_DEPTH; i++)
      a_push(mk(int'(i % 16 == 0), int'(i % 16 == 15), 0, 64'h1000 + 64'(i)));
    a_cycles(2);
    @(negedge clk);
    chk("full_fill_level", 64'(a_fill), 64'd128);
    chk("full_sink_ready", 64'(a_ready), 64'd0);
    chk("full_almost_full", 64'(a_af), 64'd1);
    chk("full_pkt_count", 64'(a_pkt), 64'd8);
    @(posedge clk); #1;
    a_src_ready = 1'b1;
    @(posedge clk); #1;
    a_src_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_one_read", 64'(a_ready), 64'd1);
    chk("almost_full_at_127", 64'(a_af), 64'd1);
    @(posedge clk); #1;
    a_rmode = 1;
    a_cycles(4);
    a_src_ready = 1'b0;
    @(negedge clk);
    chk("almost_full_clear_at_123", 64'(a_af), 64'd0);
    @(posedge clk); #1;
    a_cycles(130);

    // EOP written and read in the same cycle.
    a_rmode = 0;
    a_push(mk(1, 1, 0, 64'hA0));
    a_push(mk(1, 0, 0, 64'hA1));
    for (int i = 2; i < 5; i++) a_push(mk(0, 0, 0, 64'hA0 + 64'(i)));
    @(negedge clk);
    chk("level5_fill", 64'(a_fill), 64'd5);
    chk("level5_pkt", 64'(a_pkt), 64'd1);
    @(posedge clk); #1;
    a_in = mk(0, 1, 5, 64'hA5);
    a_valid = 1'b1;
    a_src_ready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_src_ready = 1'b0;
    @(negedge clk);
    chk("simul_eop_fill", 64'(a_fill), 64'd5);
    chk("simul_eop_pkt", 64'(a_pkt), 64'd1);
    @(posedge clk); #1;

    // Reset while traffic is in flight.
    a_in = mk(0, 0, 0, 64'hBAD);
    a_valid = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    a_valid = 1'b0;
    @(negedge clk);
    chk("midreset_fill", 64'(a_fill), 64'd0);
    chk("midreset_pkt", 64'(a_pkt), 64'd0);
    chk("midreset_valid", 64'(a_out_valid), 64'd0);
    chk("midreset_ready", 64'(a_ready), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Store-and-forward: 10-beat packet held until its EOP is stored.
    b_rmode = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        @(negedge clk);
        chk("sf_valid_before_eop", 64'(b_out_valid), 64'd0);
        @(posedge clk); #1;
      end
      b_push(mk(int'(i == 0), int'(i == 9), 0, 64'h5000 + 64'(i)));
    end
    @(negedge clk);
    chk("sf_valid_after_eop", 64'(b_out_valid), 64'd1);
    chk("sf_pkt_count_one", 64'(b_pkt), 64'd1);
    @(posedge clk); #1;
    b_cycles(12);
    @(negedge clk);
    chk("sf_pkt_count_zero", 64'(b_pkt), 64'd0);
    chk("sf_drained_fill", 64'(b_fill), 64'd0);
    @(posedge clk); #1;

    // Oversized 40-beat packet escapes through the full condition.
    for (int i = 0; i < 40; i++)
      b_push(mk(int'(i == 0), int'(i == 39), i % 8, 64'h6000 + 64'(i)));
    b_cycles(30);
    @(negedge clk);
    chk("oversize_drained_fill", 64'(b_fill), 64'd0);
    @(posedge clk); #1;

    // Random packet lengths with random backpressure.
    b_rmode = 2;
    for (int p = 0; p < 20; p++) begin
      int len;
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++) begin
        b_push(mk(int'(i == 0), int'(i == len - 1), int'($urandom_range(0, 7)),
                  {32'($urandom), 32'(p * 100 + i)}));
        if ($urandom_range(0, 4) == 0) b_cycles(1);
      end
    end
    b_rmode = 1;
    b_cycles(60);
    @(negedge clk);
    chk("random_drained_fill", 64'(b_fill), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
